jk_cmd_driver: RTL

- Initiator side of the two-state JK on/off FSM interface (states OFF/ON; OFF->ON when j=1, ON->OFF when k=1, resets to OFF).
- Accepts a stream of target output bits over a valid/ready handshake and buffers them in a small FIFO.
- Emits one j/k command per cycle so that the remote FSM's out follows the target stream.
- Checks the remote FSM's out one cycle later, resynchronises its internal model on mismatch, and counts errors.

---
 rtl/jk_pkg.sv | 26 ++
 rtl/jk_cmd_driver_if.sv | 26 ++
 rtl/jk_tgt_fifo.sv | 52 +++++
 rtl/jk_cmd_driver.sv | 100 ++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// ----------------------------------------------------------------------------
// jk_pkg: shared JK level encodings, control states and command encoder. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jk_pkg;

  localparam logic OFF = 1'b0;
  localparam logic ON  = 1'b1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Returns {j, k} that moves a JK FSM believed to be in 'mdl' to level 't'.
  function automatic logic [1:0] jk_encode(input logic mdl, input logic t);
    logic [1:0] jk;
    jk = 2'b00;
    if (mdl == OFF) jk = {t, 1'b0};
    else            jk = {1'b0, ~t};
    return jk;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cmd_driver_if.sv
// ----------------------------------------------------------------------------
// jk_cmd_driver_if: target stream handshake and JK command/feedback bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jk_cmd_driver_if;
  logic tgt_valid;
  logic tgt_bit;
  logic tgt_ready;
  logic j;
  logic k;
  logic fb_out;
  logic pop_hold;   // test hook: freezes FIFO pops so the FIFO can fill

  modport master (
    input  tgt_valid, tgt_bit, fb_out, pop_hold,
    output tgt_ready, j, k
  );

  modport slave (
    output tgt_valid, tgt_bit, fb_out, pop_hold,
    input  tgt_ready, j, k
  );
endinterface

`default_nettype wire

// File: rtl/jk_tgt_fifo.sv
// ----------------------------------------------------------------------------
// jk_tgt_fifo: 1-bit synchronous FIFO with full/empty/count. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jk_tgt_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       areset,
  input  wire logic                       push_i,
  input  wire logic                       din_i,
  input  wire logic                       pop_i,
  output logic                            dout_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/jk_cmd_driver.sv
// ----------------------------------------------------------------------------
// jk_cmd_driver: drives j/k so a remote JK FSM follows a buffered target stream. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  wire logic        clk,
  input  wire logic        areset,
  jk_cmd_driver_if.master  bus,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_full, w_empty, w_head;
  logic [CW-1:0] w_count;
  logic          w_push, w_pop, w_last, w_nz_next;
  logic          w_mismatch, w_mdl_eff;
  logic [1:0]    w_jk;

  logic             mdl_q, mdl_d;
  logic             chk_valid_q, chk_valid_d;
  logic             chk_bit_q, chk_bit_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;
  logic [1:0]       state_q, state_d;

  jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .areset  (areset),
    .push_i  (w_push),
    .din_i   (bus.tgt_bit),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign w_push = bus.tgt_valid & ~w_full;
  assign w_pop  = ~w_empty & ~bus.pop_hold;
  assign w_last = (w_count == CW'(1));

  // Trust the feedback over the model for the cycle a check disagrees.
  assign w_mismatch = chk_valid_q & (bus.fb_out != chk_bit_q);
  assign w_mdl_eff  = w_mismatch ? bus.fb_out : mdl_q;
  assign w_jk       = w_pop ? jk_encode(w_mdl_eff, w_head) : 2'b00;

  assign w_nz_next = w_push | (~w_empty & ~(w_pop & w_last));

  always_comb begin
    mdl_d       = w_pop ? w_head : w_mdl_eff;
    chk_valid_d = w_pop;
    chk_bit_d   = w_pop ? w_head : chk_bit_q;
    err_cnt_d   = err_cnt_q;
    err_flag_d  = err_flag_q;
    if (w_mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
    end
    if (w_nz_next)        state_d = RUN;
    else if (chk_valid_d) state_d = DRAIN;
    else                  state_d = IDLE;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mdl_q       <= OFF;
      chk_valid_q <= 1'b0;
      chk_bit_q   <= 1'b0;
      err_cnt_q   <= '0;
      err_flag_q  <= 1'b0;
      state_q     <= IDLE;
    end else begin
      mdl_q       <= mdl_d;
      chk_valid_q <= chk_valid_d;
      chk_bit_q   <= chk_bit_d;
      err_cnt_q   <= err_cnt_d;
      err_flag_q  <= err_flag_d;
      state_q     <= state_d;
    end
  end

  assign bus.tgt_ready = ~w_full;
  assign bus.j         = w_jk[1];
  assign bus.k         = w_jk[0];
  assign busy          = (state_q != IDLE);
  assign err_cnt       = err_cnt_q;
  assign err_flag      = err_flag_q;

endmodule

`default_nettype wire
